load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the datapath's ALU address/rt outputs and the data memory.
//  Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
//  Sub-word stores are done as read-modify-write; load results are sign/zero-extended.
//  A busy/valid handshake lets the core stall for multi-cycle accesses.
// PARAMETERS
//  ADDR_W  13  word-address width to memory; the byte address is ADDR_W+2 bits
//  DATA_W  32  data width; only 32 is supported
// PORTS
//  clock      in   1         single clock; rising edge for all state
//  reset_n    in   1         asynchronous, active-low reset
//  req_valid  in   1         request present; sampled only when req_ready=1
//  req_ready  out  1         1 only in IDLE
//  req_store  in   1         1=store, 0=load
//  req_op     in   3         000 B, 001 H, 010 W, 100 BU, 101 HU (lsu_pkg)
//  req_addr   in   ADDR_W+2  byte address
//  req_wdata  in   32        store data; B/H use low bits
//  resp_valid out  1         one-cycle pulse, in RESP state
//  resp_data  out  32        extended load data; 0 for stores and errors
//  resp_err   out  1         misaligned or illegal op; valid with resp_valid
//  mem_read   out  1         to data memory MemRead
//  mem_write  out  1         to data memory MemWrite; memory commits on the falling edge
//  mem_addr   out  ADDR_W    word address = req_addr[ADDR_W+1:2]
//  mem_wdata  out  32        to data memory Write_data
//  mem_rdata  in   32        from data memory Read_Data; combinational
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs reset to 0, except req_ready, which resets to 1.
//  mem_read and mem_write are decoded from the state register only, so an async reset
//  mid-operation drops them at once. A write cycle reset before its falling edge is lost.
//  Registered copies of op, store, address and wdata are captured on accept.
//  States:
//   IDLE: when req_valid, latch the request.
//    -> RESP with err=1 if misaligned (H: a[0]!=0; W: a[1:0]!=0) or store with op[2]=1.
//    -> else ACCESS.
//   ACCESS: mem_addr is driven.
//    Load, SB or SH: mem_read=1; mem_rdata is captured into rbuf at the rising edge.
//    SW: mem_write=1, mem_wdata=wdata.
//    Exit: SB/SH go to WRITE; all others go to RESP.
//   WRITE: mem_write=1, mem_wdata = rbuf with the addressed lane(s) replaced. -> RESP.
//   RESP: resp_valid=1 for exactly one cycle. -> IDLE.
//  Lane order is little-endian: byte offset 0 is bits[7:0], halfword offset 2 is [31:16].
//  Loads: extract the lane from rbuf. B/H sign-extend; BU/HU zero-extend.
//  Latency from accept edge to resp_valid:
//   load: 2 cycles; SW: 2; SB/SH: 3; error: 1.
//  Throughput: one request per RESP->IDLE round trip. req_valid during a busy state is ignored.
//  mem_addr and mem_wdata hold stable throughout ACCESS and WRITE.
//  They hold their last value in IDLE/RESP with mem_read=mem_write=0.
//  The full byte-address range maps to 2^ADDR_W words; there is no out-of-range case.
//  Address wrap is impossible.
// STRUCTURE
//  lsu_pkg: op encodings (OP_B, OP_H, OP_W, OP_BU, OP_HU), state encoding
//   (IDLE, ACCESS, WRITE, RESP), and the misalign-check function.
//  Sub-module lsu_lane: purely combinational. Inputs: word, offset, op, wdata.
//   Outputs: merged store word and extended load value.
//  The top level holds the FSM, request registers and rbuf.
// TESTING
//  Reference memory model: writes on negedge, combinational read, initialised to known values.
//  1. SW addr 0x0010 data 0xDEADBEEF -> mem_write 1 cycle at word 4; resp 2 cycles
//     after accept; LW 0x0010 returns 0xDEADBEEF.
//  2. Word 4=0x11223344: SB addr 0x0011 data 0xAA -> word 4=0x1122AA44;
//     mem_read then mem_write in consecutive cycles.
//  3. Word 4=0x8000FF7F: LB 0x0012 -> 0x00000000; LB 0x0011 -> 0xFFFFFFFF;
//     LBU 0x0011 -> 0x000000FF; LH 0x0012 -> 0xFFFF8000; LHU -> 0x00008000.
//  4. LW 0x0013, SH 0x0011, store op=100 -> resp_err=1 one cycle after accept;
//     no mem_read/mem_write pulse; memory unchanged.
//  5. Assert reset_n=0 during WRITE before the falling edge -> no memory change;
//     outputs 0, req_ready=1. Next request is serviced normally.
//  6. Back-to-back req_valid held high -> second request accepted only after RESP;
//     the request is never duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the request legality check applied at accept time.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Misaligned halfword/word, undefined encoding, or an unsigned-store encoding.
  function automatic logic req_error(input logic [2:0] op, input logic store,
                                     input logic [1:0] off);
    logic err;
    case (op)
      OP_B, OP_BU: err = 1'b0;
      OP_H, OP_HU: err = off[0];
      OP_W:        err = (off != 2'b00);
      default:     err = 1'b1;
    endcase
    return err | (store & op[2]);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: merges store data into a fetched word and
// extracts/extends the addressed lane for loads. Purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_val_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    st_word_o = word_i;
    case (op_i[1:0])
      2'b00: st_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      2'b01: begin
        if (offset_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else             st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase

    case (op_i)
      OP_B:    ld_val_o = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   ld_val_o = {24'h0, byte_sel};
      OP_H:    ld_val_o = {{16{half_sel[15]}}, half_sel};
      OP_HU:   ld_val_o = {16'h0, half_sel};
      default: ld_val_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory. Sub-word
// stores are read-modify-write; handshake: a request is taken when req_valid && req_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q;
  logic [2:0]        op_q;
  logic              store_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [DATA_W-1:0] st_word;
  logic [DATA_W-1:0] ld_val;
  logic              is_sw;

  lsu_lane u_lane (
    .word_i    (rbuf_q),
    .offset_i  (off_q),
    .op_i      (op_q),
    .wdata_i   (wdata_q),
    .st_word_o (st_word),
    .ld_val_o  (ld_val)
  );

  assign is_sw = store_q && (op_q == OP_W);

  // Strobes come straight from the state register so an async reset kills them immediately.
  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == ACCESS) && !is_sw;
  assign mem_write  = ((state_q == ACCESS) && is_sw) || (state_q == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = (state_q == WRITE) ? st_word : mem_wdata_q;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_data  = ((state_q == RESP) && !store_q && !err_q) ? ld_val : '0;
  assign dbg_state  = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      store_q     <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rbuf_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            store_q <= req_store;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_error(req_op, req_store, req_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              err_q       <= 1'b0;
              mem_addr_q  <= req_addr[ADDR_W+1:2];
              mem_wdata_q <= req_wdata;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_read) rbuf_q <= mem_rdata;
          state_q <= (store_q && !is_sw) ? WRITE : RESP;
        end
        WRITE: begin
          // Keep the merged word on the bus after the write so mem_wdata holds its last value.
          mem_wdata_q <= st_word;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-write reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 13;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_op;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  lsu_state_e        dbg_state;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int tests_run = 0;
  int failed    = 0;
  int lat, rd_n, wr_n, rd_at, wr_at;
  int n_resp, n_rd, n_rdy;
  logic [31:0] rdata;
  logic        rerr;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  always @(negedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then record latency (negedges-equivalent sample points after accept),
  // read/write strobe counts and the response fields.
  task automatic do_req(input logic st, input logic [2:0] op, input logic [ADDR_W+1:0] addr,
                        input logic [31:0] wd);
    @(negedge clock);
    req_store = st; req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0; rdata = 'x; rerr = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (resp_valid) begin
        lat = i; rdata = resp_data; rerr = resp_err;
        break;
      end
      if (mem_read)  begin rd_n++; rd_at = i; end
      if (mem_write) begin wr_n++; wr_at = i; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  task automatic check_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                            input logic exp_err);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, rdata, exp_data);
    check({tag, "_err"}, {31'b0, rerr}, {31'b0, exp_err});
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_op = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h5A5A0000 + i;

    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rd", {31'b0, mem_read}, 32'd0);
    check("rst_wr", {31'b0, mem_write}, 32'd0);
    check("rst_addr", {19'b0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(negedge clock); reset_n = 1'b1;

    // 1: SW then LW
    do_req(1'b1, OP_W, 15'h0010, 32'hDEADBEEF);
    check_resp("sw", 2, 32'h0, 1'b0);
    check("sw_wr_n", wr_n, 1);
    check("sw_rd_n", rd_n, 0);
    check("sw_mem4", mem[4], 32'hDEADBEEF);
    do_req(1'b0, OP_W, 15'h0010, 32'h0);
    check_resp("lw", 2, 32'hDEADBEEF, 1'b0);
    check("lw_rd_n", rd_n, 1);

    // 2: sub-word read-modify-write
    do_req(1'b1, OP_W, 15'h0010, 32'h11223344);
    do_req(1'b1, OP_B, 15'h0011, 32'h000000AA);
    check_resp("sb", 3, 32'h0, 1'b0);
    check("sb_mem4", mem[4], 32'h1122AA44);
    check("sb_rd_n", rd_n, 1);
    check("sb_wr_n", wr_n, 1);
    check("sb_order", wr_at, rd_at + 1);
    do_req(1'b1, OP_H, 15'h0012, 32'h1234BEEF);
    check_resp("sh", 3, 32'h0, 1'b0);
    check("sh_mem4", mem[4], 32'hBEEFAA44);
    check("sh_mem5", mem[5], 32'h5A5A0005);

    // 3: load extension
    do_req(1'b1, OP_W, 15'h0010, 32'h8000FF7F);
    do_req(1'b0, OP_B, 15'h0012, 32'h0);  check_resp("lb2", 2, 32'h00000000, 1'b0);
    do_req(1'b0, OP_B, 15'h0011, 32'h0);  check_resp("lb1", 2, 32'hFFFFFFFF, 1'b0);
    do_req(1'b0, OP_BU, 15'h0011, 32'h0); check_resp("lbu1", 2, 32'h000000FF, 1'b0);
    do_req(1'b0, OP_H, 15'h0012, 32'h0);  check_resp("lh2", 2, 32'hFFFF8000, 1'b0);
    do_req(1'b0, OP_HU, 15'h0012, 32'h0); check_resp("lhu2", 2, 32'h00008000, 1'b0);
    do_req(1'b0, OP_B, 15'h0010, 32'h0);  check_resp("lb0", 2, 32'h0000007F, 1'b0);
    do_req(1'b0, OP_B, 15'h0013, 32'h0);  check_resp("lb3", 2, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, OP_HU, 15'h0010, 32'h0); check_resp("lhu0", 2, 32'h0000FF7F, 1'b0);

    // 4: errors
    do_req(1'b0, OP_W, 15'h0013, 32'h0);
    check_resp("lw_mis", 1, 32'h0, 1'b1);
    check("lw_mis_strobes", rd_n + wr_n, 0);
    do_req(1'b1, OP_H, 15'h0011, 32'hFFFFFFFF);
    check_resp("sh_mis", 1, 32'h0, 1'b1);
    check("sh_mis_strobes", rd_n + wr_n, 0);
    do_req(1'b1, OP_BU, 15'h0010, 32'hFFFFFFFF);
    check_resp("sbu_ill", 1, 32'h0, 1'b1);
    check("sbu_ill_strobes", rd_n + wr_n, 0);
    do_req(1'b0, 3'b011, 15'h0010, 32'h0);
    check_resp("op_ill", 1, 32'h0, 1'b1);
    check("err_mem4", mem[4], 32'h8000FF7F);

    // 5: reset during WRITE, before the memory's falling edge
    @(negedge clock);
    req_store = 1'b1; req_op = OP_B; req_addr = 15'h0010; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clock); #1; req_valid = 1'b0;
    @(posedge clock); #1;
    check("rw_in_write", {31'b0, mem_write}, 32'd1);
    reset_n = 1'b0; #1;
    check("rw_wr", {31'b0, mem_write}, 32'd0);
    check("rw_rd", {31'b0, mem_read}, 32'd0);
    check("rw_ready", {31'b0, req_ready}, 32'd1);
    check("rw_addr", {19'b0, mem_addr}, 32'd0);
    check("rw_wdata", mem_wdata, 32'd0);
    @(negedge clock); #1;
    check("rw_mem4", mem[4], 32'h8000FF7F);
    reset_n = 1'b1;
    do_req(1'b1, OP_B, 15'h0010, 32'h55);
    check_resp("rw_sb", 3, 32'h0, 1'b0);
    check("rw_sb_mem4", mem[4], 32'h8000FF55);

    // 6: req_valid held across two full transactions
    @(negedge clock);
    req_store = 1'b0; req_op = OP_W; req_addr = 15'h0010; req_valid = 1'b1;
    n_resp = 0; n_rd = 0; n_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      n_resp += int'(resp_valid); n_rd += int'(mem_read); n_rdy += int'(req_ready);
      if (resp_valid) check("b2b_data", resp_data, 32'h8000FF55);
    end
    req_valid = 1'b0;
    check("b2b_resp_n", n_resp, 2);
    check("b2b_rd_n", n_rd, 2);
    check("b2b_rdy_n", n_rdy, 2);
    @(posedge clock); #1;
    check("b2b_idle", {31'b0, req_ready}, 32'd1);
    check("b2b_norsp", {31'b0, resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
